// File: rtl/nh_lcd_bus_responder.sv
// Panel-side responder for the 8080-style 8-bit LCD bus: decodes commands, parameters and RGB pixels, answers ID reads.
// Optional tearing-effect pulse generator enabled by defining NH_LCD_RESP_TEARING_EN.
module nh_lcd_bus_responder #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] MEMWRITE_CMD = 8'h2C,
  parameter logic [7:0] MEMCONT_CMD  = 8'h3C,
  parameter logic [7:0] READ_ID_CMD  = 8'h04,
  parameter int         TE_WIDTH     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_panel_reset_n,
  input  logic        i_cs_n,
  input  logic        i_rs,
  input  logic        i_write_n,
  input  logic        i_read_n,
  inout  wire  [7:0]  io_data,
  input  logic [23:0] i_id,
  input  logic [31:0] i_num_pixels,
  input  logic        i_pix_rdy,
  input  logic        i_clear,
  output logic        o_cmd_stb,
  output logic [7:0]  o_cmd,
  output logic        o_param_stb,
  output logic [7:0]  o_param,
  output logic        o_pix_stb,
  output logic [23:0] o_pix,
  output logic [31:0] o_pix_count,
  output logic        o_frame_done,
  output logic        o_overrun,
  output logic        o_protocol_err,
  output logic        o_tearing_effect
);

  typedef enum logic [1:0] {IDLE, PARAM, PIX} state_t;
  state_t state, state_nx;

  logic [SYNC_STAGES-1:0]      cs_sync, wr_sync, rd_sync, rs_sync;
  logic [SYNC_STAGES-1:0][7:0] d_sync;
  logic       wr_prev, rd_prev, conflict;
  logic       cs_s, wr_s, rd_s, rs_s;
  logic [7:0] d_s;
  logic       both_low, qual, wr_edge, rd_fall, rd_rise, is_cmd, is_dat, pix_done, ovr_set;
  logic [1:0] byte_idx, rd_idx;
  logic       id_armed, drive_en;
  logic [7:0] rd_data, rd_val;
  logic [15:0] pix_buf;
  logic [31:0] cnt_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync  <= '1;
      wr_sync  <= '1;
      rd_sync  <= '1;
      rs_sync  <= '0;
      d_sync   <= '0;
      wr_prev  <= 1'b1;
      rd_prev  <= 1'b1;
      conflict <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
      wr_sync  <= {wr_sync[SYNC_STAGES-2:0], i_write_n};
      rd_sync  <= {rd_sync[SYNC_STAGES-2:0], i_read_n};
      rs_sync  <= {rs_sync[SYNC_STAGES-2:0], i_rs};
      d_sync   <= {d_sync[SYNC_STAGES-2:0], io_data};
      wr_prev  <= wr_s;
      rd_prev  <= rd_s;
      // once both strobes collide, every edge is ignored until both are back high
      conflict <= both_low | (conflict & ~(wr_s & rd_s));
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign wr_s     = wr_sync[SYNC_STAGES-1];
  assign rd_s     = rd_sync[SYNC_STAGES-1];
  assign rs_s     = rs_sync[SYNC_STAGES-1];
  assign d_s      = d_sync[SYNC_STAGES-1];
  assign both_low = ~cs_s & ~wr_s & ~rd_s;
  assign qual     = ~cs_s & ~conflict & ~both_low;
  assign wr_edge  = qual & wr_s & ~wr_prev;
  assign rd_fall  = qual & ~rd_s & rd_prev;
  assign rd_rise  = rd_s & ~rd_prev;
  assign is_cmd   = wr_edge & ~rs_s;
  assign is_dat   = wr_edge & rs_s;
  assign pix_done = is_dat & (state == PIX) & (byte_idx == 2'd2);
  assign ovr_set  = i_panel_reset_n & pix_done & ~i_pix_rdy;
  assign cnt_nx   = o_pix_count + 32'd1;

  always_comb begin
    rd_val = 8'h00;
    if (id_armed) begin
      case (rd_idx)
        2'd0:    rd_val = i_id[23:16];
        2'd1:    rd_val = i_id[15:8];
        2'd2:    rd_val = i_id[7:0];
        default: rd_val = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!i_panel_reset_n) state_nx = IDLE;
    else if (is_cmd) begin
      if (d_s == MEMWRITE_CMD || d_s == MEMCONT_CMD) state_nx = PIX;
      else if (d_s == READ_ID_CMD)                   state_nx = IDLE;
      else                                           state_nx = PARAM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_cmd_stb    <= 1'b0;
      o_cmd        <= '0;
      o_param_stb  <= 1'b0;
      o_param      <= '0;
      o_pix_stb    <= 1'b0;
      o_pix        <= '0;
      o_pix_count  <= '0;
      o_frame_done <= 1'b0;
      pix_buf      <= '0;
      byte_idx     <= '0;
      rd_idx       <= '0;
      id_armed     <= 1'b0;
      drive_en     <= 1'b0;
      rd_data      <= '0;
    end else begin
      o_cmd_stb    <= 1'b0;
      o_param_stb  <= 1'b0;
      o_pix_stb    <= 1'b0;
      o_frame_done <= 1'b0;
      if (!i_panel_reset_n) begin
        byte_idx    <= '0;
        o_pix_count <= '0;
        rd_idx      <= '0;
        id_armed    <= 1'b0;
        drive_en    <= 1'b0;
      end else begin
        if (is_cmd) begin
          o_cmd_stb <= 1'b1;
          o_cmd     <= d_s;
          byte_idx  <= '0;
          id_armed  <= (d_s == READ_ID_CMD);
          if (d_s == MEMWRITE_CMD) o_pix_count <= '0;
          if (d_s == READ_ID_CMD)  rd_idx <= '0;
        end else if (is_dat && state == PARAM) begin
          o_param_stb <= 1'b1;
          o_param     <= d_s;
        end else if (is_dat && state == PIX) begin
          case (byte_idx)
            2'd0:    begin pix_buf[15:8] <= d_s; byte_idx <= 2'd1; end
            2'd1:    begin pix_buf[7:0]  <= d_s; byte_idx <= 2'd2; end
            default: begin
              byte_idx <= 2'd0;
              if (i_pix_rdy) begin
                o_pix_stb <= 1'b1;
                o_pix     <= {pix_buf, d_s};
                if (i_num_pixels != 32'd0 && cnt_nx == i_num_pixels) begin
                  o_frame_done <= 1'b1;
                  o_pix_count  <= '0;
                end else begin
                  o_pix_count <= cnt_nx;
                end
              end
            end
          endcase
        end
        if (rd_fall) begin
          drive_en <= 1'b1;
          rd_data  <= rd_val;
          if (rd_idx != 2'd3) rd_idx <= rd_idx + 2'd1;
        end else if (rd_rise || both_low) begin
          drive_en <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_overrun      <= 1'b0;
      o_protocol_err <= 1'b0;
    end else begin
      o_overrun      <= ovr_set  | (o_overrun & ~i_clear);
      o_protocol_err <= both_low | (o_protocol_err & ~i_clear);
    end
  end

  assign io_data = drive_en ? rd_data : 8'hzz;

`ifdef NH_LCD_RESP_TEARING_EN
  localparam int TW = $clog2(TE_WIDTH + 1);
  logic [TW-1:0] te_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                te_cnt <= '0;
    else if (o_frame_done)   te_cnt <= TW'(TE_WIDTH);
    else if (te_cnt != '0)   te_cnt <= te_cnt - 1'b1;
  end

  assign o_tearing_effect = (te_cnt != '0);
`else
  assign o_tearing_effect = 1'b0;
`endif

endmodule

// File: tb/tb_nh_lcd_bus_responder.sv
// Directed bench for nh_lcd_bus_responder: writes, pixel assembly, overrun, ID reads, protocol error, resets.
module tb_nh_lcd_bus_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_panel_reset_n = 1'b1;
  logic        i_cs_n = 1'b1, i_rs = 1'b0, i_write_n = 1'b1, i_read_n = 1'b1;
  logic [23:0] i_id = '0;
  logic [31:0] i_num_pixels = '0;
  logic        i_pix_rdy = 1'b1, i_clear = 1'b0;
  logic        o_cmd_stb, o_param_stb, o_pix_stb, o_frame_done, o_overrun, o_protocol_err, o_tearing_effect;
  logic [7:0]  o_cmd, o_param;
  logic [23:0] o_pix;
  logic [31:0] o_pix_count;
  logic        tb_oe = 1'b0;
  logic [7:0]  tb_d = '0;
  tri1  [7:0]  io_data;

  assign io_data = tb_oe ? tb_d : 8'hzz;

  always #5 clk = ~clk;

  nh_lcd_bus_responder dut (
    .clk(clk), .rst(rst), .i_panel_reset_n(i_panel_reset_n), .i_cs_n(i_cs_n), .i_rs(i_rs),
    .i_write_n(i_write_n), .i_read_n(i_read_n), .io_data(io_data), .i_id(i_id),
    .i_num_pixels(i_num_pixels), .i_pix_rdy(i_pix_rdy), .i_clear(i_clear),
    .o_cmd_stb(o_cmd_stb), .o_cmd(o_cmd), .o_param_stb(o_param_stb), .o_param(o_param),
    .o_pix_stb(o_pix_stb), .o_pix(o_pix), .o_pix_count(o_pix_count), .o_frame_done(o_frame_done),
    .o_overrun(o_overrun), .o_protocol_err(o_protocol_err), .o_tearing_effect(o_tearing_effect)
  );

  int n_cmp = 0, n_err = 0;
  int te_hi = 0, te_base = 0;

  always @(negedge clk) if (o_tearing_effect) te_hi <= te_hi + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // snapshot of the first strobe seen after a write
  int          s_cyc;
  logic        s_cmd_stb, s_param_stb, s_pix_stb, s_fd;
  logic [7:0]  s_cmd, s_param;
  logic [23:0] s_pix;
  logic [31:0] s_cnt;

  task automatic wr_byte(input logic rs, input logic [7:0] d);
    @(negedge clk);
    i_cs_n = 1'b0; i_rs = rs; tb_d = d; tb_oe = 1'b1; i_write_n = 1'b0;
    repeat (3) @(negedge clk);
    i_write_n = 1'b1;
    s_cyc = 0; s_cmd_stb = 0; s_param_stb = 0; s_pix_stb = 0; s_fd = 0;
    s_cmd = '0; s_param = '0; s_pix = '0; s_cnt = '0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (s_cyc == 0 && (o_cmd_stb || o_param_stb || o_pix_stb)) begin
        s_cyc = k; s_cmd_stb = o_cmd_stb; s_param_stb = o_param_stb; s_pix_stb = o_pix_stb;
        s_fd = o_frame_done; s_cmd = o_cmd; s_param = o_param; s_pix = o_pix; s_cnt = o_pix_count;
      end
    end
    tb_oe = 1'b0;
  endtask

  task automatic rd_byte(input string tag, input logic [7:0] exp);
    @(negedge clk);
    tb_oe = 1'b0; i_cs_n = 1'b0; i_read_n = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, "_data"}, {24'h0, io_data}, {24'h0, exp});
    i_read_n = 1'b1;
    repeat (5) @(negedge clk);
    chk({tag, "_hiz"}, {24'h0, io_data}, 32'h0000_00FF);
  endtask

  task automatic collide();
    @(negedge clk);
    i_cs_n = 1'b0; i_write_n = 1'b0; i_read_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic release_both();
    i_write_n = 1'b1; i_read_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd_stb", {31'h0, o_cmd_stb}, 32'h0);
    chk("rst_cmd", {24'h0, o_cmd}, 32'h0);
    chk("rst_count", o_pix_count, 32'h0);
    chk("rst_overrun", {31'h0, o_overrun}, 32'h0);
    chk("rst_perr", {31'h0, o_protocol_err}, 32'h0);
    chk("rst_hiz", {24'h0, io_data}, 32'h0000_00FF);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // command then parameter, strobe latency SYNC_STAGES+1
    wr_byte(1'b0, 8'h36);
    chk("t1_cmd_lat", s_cyc, 3);
    chk("t1_cmd_stb", {31'h0, s_cmd_stb}, 32'h1);
    chk("t1_cmd", {24'h0, s_cmd}, 32'h36);
    wr_byte(1'b1, 8'h48);
    chk("t1_par_lat", s_cyc, 3);
    chk("t1_par_stb", {31'h0, s_param_stb}, 32'h1);
    chk("t1_par", {24'h0, s_param}, 32'h48);

    // two-pixel frame
    i_num_pixels = 32'd2;
    te_base = te_hi;
    wr_byte(1'b0, 8'h2C);
    chk("t2_cmd", {24'h0, s_cmd}, 32'h2C);
    wr_byte(1'b1, 8'h11);
    chk("t2_nostb_r", s_cyc, 0);
    wr_byte(1'b1, 8'h22);
    wr_byte(1'b1, 8'h33);
    chk("t2_pix0_lat", s_cyc, 3);
    chk("t2_pix0_stb", {31'h0, s_pix_stb}, 32'h1);
    chk("t2_pix0", {8'h0, s_pix}, 32'h0011_2233);
    chk("t2_cnt0", s_cnt, 32'd1);
    chk("t2_fd0", {31'h0, s_fd}, 32'h0);
    wr_byte(1'b1, 8'h44);
    wr_byte(1'b1, 8'h55);
    wr_byte(1'b1, 8'h66);
    chk("t2_pix1", {8'h0, s_pix}, 32'h0044_5566);
    chk("t2_fd1", {31'h0, s_fd}, 32'h1);
    chk("t2_cnt1", s_cnt, 32'd0);
    repeat (25) @(negedge clk);
`ifdef NH_LCD_RESP_TEARING_EN
    chk("t6_te_width", te_hi - te_base, 16);
`else
    chk("t6_te_off", te_hi - te_base, 0);
`endif

    // partial pixel discarded by a new command
    i_num_pixels = 32'd0;
    wr_byte(1'b0, 8'h2C);
    wr_byte(1'b1, 8'hAA);
    wr_byte(1'b1, 8'hBB);
    wr_byte(1'b0, 8'h2C);
    wr_byte(1'b1, 8'h01);
    wr_byte(1'b1, 8'h02);
    wr_byte(1'b1, 8'h03);
    chk("t3_pix", {8'h0, s_pix}, 32'h0001_0203);
    chk("t3_cnt", s_cnt, 32'd1);

    // overrun, then continue without clearing the count
    i_pix_rdy = 1'b0;
    wr_byte(1'b1, 8'h04);
    wr_byte(1'b1, 8'h05);
    wr_byte(1'b1, 8'h06);
    chk("t4_nostb", s_cyc, 0);
    chk("t4_overrun", {31'h0, o_overrun}, 32'h1);
    chk("t4_cnt_held", o_pix_count, 32'd1);
    i_pix_rdy = 1'b1;
    wr_byte(1'b0, 8'h3C);
    wr_byte(1'b1, 8'h07);
    wr_byte(1'b1, 8'h08);
    wr_byte(1'b1, 8'h09);
    chk("t4_cont_pix", {8'h0, s_pix}, 32'h0007_0809);
    chk("t4_cont_cnt", s_cnt, 32'd2);
    chk("t4_ovr_sticky", {31'h0, o_overrun}, 32'h1);
    @(negedge clk); i_clear = 1'b1;
    @(negedge clk); i_clear = 1'b0;
    chk("t4_ovr_clr", {31'h0, o_overrun}, 32'h0);

    // soft panel reset clears the count
    @(negedge clk); i_panel_reset_n = 1'b0;
    @(negedge clk); i_panel_reset_n = 1'b1;
    chk("pr_count", o_pix_count, 32'd0);

    // ID readback
    i_id = 24'h5A1234;
    wr_byte(1'b0, 8'h04);
    rd_byte("t5_rd0", 8'h5A);
    rd_byte("t5_rd1", 8'h12);
    rd_byte("t5_rd2", 8'h34);
    rd_byte("t5_rd3", 8'h00);
    wr_byte(1'b0, 8'h36);
    rd_byte("t5_unarmed", 8'h00);

    // collision of write and read strobes
    collide();
    chk("t5_perr", {31'h0, o_protocol_err}, 32'h1);
    chk("t5_perr_hiz", {24'h0, io_data}, 32'h0000_00FF);
    release_both();
    chk("t5_perr_ignored", {24'h0, o_cmd}, 32'h36);
    @(negedge clk); i_clear = 1'b1;
    @(negedge clk); i_clear = 1'b0;
    chk("t5_perr_clr", {31'h0, o_protocol_err}, 32'h0);
    collide();
    release_both();

    // async reset mid-pixel
    wr_byte(1'b0, 8'h2C);
    wr_byte(1'b1, 8'hC1);
    wr_byte(1'b1, 8'hC2);
    wr_byte(1'b1, 8'hC3);
    chk("t6_pre_cnt", s_cnt, 32'd1);
    wr_byte(1'b1, 8'hD1);
    @(negedge clk); rst = 1'b0; #1;
    chk("t6_cmd", {24'h0, o_cmd}, 32'h0);
    chk("t6_param", {24'h0, o_param}, 32'h0);
    chk("t6_pix", {8'h0, o_pix}, 32'h0);
    chk("t6_count", o_pix_count, 32'h0);
    chk("t6_perr", {31'h0, o_protocol_err}, 32'h0);
    chk("t6_hiz", {24'h0, io_data}, 32'h0000_00FF);
    chk("t6_te", {31'h0, o_tearing_effect}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
